// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage: fixed-latency reads with address echo,
// plus a program-load write port. Memory contents are not reset.
module imem_responder #(
  parameter int unsigned         ADDR_W    = 13,
  parameter int unsigned         DATA_W    = 16,
  parameter int unsigned         DEPTH     = 8192,
  parameter int unsigned         LATENCY   = 2,
  parameter logic [DATA_W-1:0]   NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_instr,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              resp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int unsigned       CW       = $clog2(LATENCY) + 1;
  localparam int unsigned       IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [CW-1:0]     CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic              rd_in, ld_in;
  logic              accept, do_resp;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    req_ready = rst && (state == IDLE || state == RESP) && !ld_en && !flush;
    accept    = req_valid && req_ready;
    rd_in     = ({1'b0, rd_addr} < DEPTH_W);
    ld_in     = ({1'b0, ld_addr} < DEPTH_W);
    rd_word   = mem[rd_addr[IW-1:0]];
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    do_resp = 1'b0;
    rd_addr = addr_q;
    case (state)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          // Single-cycle latency reads the incoming address directly, since addr_q
          // only captures it at this same edge.
          if (LATENCY == 1) begin
            do_resp = 1'b1;
            rd_addr = req_addr;
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          do_resp = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      resp_valid <= 1'b0;
      resp_instr <= '0;
      resp_addr  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      resp_valid <= do_resp;
      if (accept) begin
        addr_q <= req_addr;
      end
      if (do_resp) begin
        resp_addr  <= rd_addr;
        resp_err   <= !rd_in;
        resp_instr <= rd_in ? rd_word : NOP_INSTR;
      end
    end
  end

  // Read-before-write: a load on the response edge is not seen by that response.
  always_ff @(posedge clk) begin
    if (ld_en && ld_in) begin
      mem[ld_addr[IW-1:0]] <= ld_data;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three builds (LATENCY 2, LATENCY 1, LATENCY 3 / DEPTH 16)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        ld_en = 1'b0;
  logic [12:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  logic        rvq [3];
  logic [12:0] raq [3];
  logic        rdy [3];
  logic        rsv [3];
  logic [15:0] rsi [3];
  logic [12:0] rsa [3];
  logic        rse [3];

  logic [15:0] pat [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .req_valid(rvq[0]), .req_addr(raq[0]), .req_ready(rdy[0]),
    .flush(flush), .resp_valid(rsv[0]), .resp_instr(rsi[0]), .resp_addr(rsa[0]),
    .resp_err(rse[0]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rvq[1]), .req_addr(raq[1]), .req_ready(rdy[1]),
    .flush(flush), .resp_valid(rsv[1]), .resp_instr(rsi[1]), .resp_addr(rsa[1]),
    .resp_err(rse[1]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_responder #(.LATENCY(3), .DEPTH(16)) u2 (
    .clk(clk), .rst(rst), .req_valid(rvq[2]), .req_addr(raq[2]), .req_ready(rdy[2]),
    .flush(flush), .resp_valid(rsv[2]), .resp_instr(rsi[2]), .resp_addr(rsa[2]),
    .resp_err(rse[2]), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request accepted at cycle c answers on edge c+LAT-1.
  function automatic int lat(input int i);
    return (i == 1) ? 1 : ((i == 2) ? 3 : 2);
  endfunction

  function automatic int dep(input int i);
    return (i == 2) ? 16 : 8192;
  endfunction

  logic [15:0] mm [3][8192];
  bit          mk [3][8192];
  bit          pend [3];
  int          due [3];
  logic [12:0] paddr [3];
  logic        m_rv [3];
  logic [15:0] m_ri [3];
  logic [12:0] m_ra [3];
  logic        m_re [3];
  bit          m_kn [3];
  int          cyc = 0;

  task automatic respond(input int i, input logic [12:0] a);
    m_rv[i] = 1'b1;
    m_ra[i] = a;
    if (int'(a) < dep(i)) begin
      m_re[i] = 1'b0;
      m_ri[i] = mm[i][a];
      m_kn[i] = mk[i][a];
    end else begin
      m_re[i] = 1'b1;
      m_ri[i] = 16'h0000;
      m_kn[i] = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          pend[i] = 1'b0;
          m_rv[i] = 1'b0;
          m_ri[i] = '0;
          m_ra[i] = '0;
          m_re[i] = 1'b0;
          m_kn[i] = 1'b1;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          m_rv[i] = 1'b0;
          if (pend[i]) begin
            if (flush) begin
              pend[i] = 1'b0;
            end else if (cyc == due[i]) begin
              pend[i] = 1'b0;
              respond(i, paddr[i]);
            end
          end else if (rvq[i] && !ld_en && !flush) begin
            if (lat(i) == 1) begin
              respond(i, raq[i]);
            end else begin
              pend[i]  = 1'b1;
              paddr[i] = raq[i];
              due[i]   = cyc + lat(i) - 1;
            end
          end
        end
        if (ld_en) begin
          for (int i = 0; i < 3; i++) begin
            if (int'(ld_addr) < dep(i)) begin
              mm[i][ld_addr] = ld_data;
              mk[i][ld_addr] = 1'b1;
            end
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_ready%0d", i), rdy[i], rst && !pend[i] && !ld_en && !flush);
        chk($sformatf("model_valid%0d", i), rsv[i], m_rv[i]);
        chk($sformatf("model_addr%0d", i), rsa[i], m_ra[i]);
        chk($sformatf("model_err%0d", i), rse[i], m_re[i]);
        if (m_kn[i]) chk($sformatf("model_instr%0d", i), rsi[i], m_ri[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic load(input logic [12:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rvq[i] = 1'b0;
      raq[i] = '0;
    end
    #2 rst = 1'b0;
    samp();
    chk("reset_ready", rdy[0], 0);
    chk("reset_valid", rsv[0], 0);
    chk("reset_instr", rsi[0], 0);
    chk("reset_addr", rsa[0], 0);
    chk("reset_err", rse[0], 0);
    step();
    rst = 1'b1;

    for (int j = 0; j < 4; j++) load(13'(j), pat[j]);
    load(13'd5, 16'h5555);
    load(13'h0020, 16'hBEEF);
    step();

    // single request, LATENCY 2
    rvq[0] = 1'b1; raq[0] = 13'd0;
    samp(); chk("t1_ready", rdy[0], 1);
    step(); rvq[0] = 1'b0;
    samp(); chk("t1_wait_valid", rsv[0], 0);
    step();
    samp();
    chk("t1_valid", rsv[0], 1);
    chk("t1_instr", rsi[0], 16'h1111);
    chk("t1_addr", rsa[0], 0);
    chk("t1_err", rse[0], 0);
    step();
    samp(); chk("t1_pulse_end", rsv[0], 0);

    // sustained, LATENCY 2: pulses every other cycle
    step();
    rvq[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      raq[0] = 13'(j);
      step();
      samp(); chk("t2_gap", rsv[0], 0);
      step();
      samp(); chk("t2_valid", rsv[0], 1); chk("t2_instr", rsi[0], pat[j]);
    end
    rvq[0] = 1'b0;
    step();
    samp(); chk("t2_idle", rsv[0], 0);

    // sustained, LATENCY 1: consecutive pulses
    step();
    rvq[1] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      raq[1] = 13'(j);
      step();
      samp(); chk("t3_valid", rsv[1], 1); chk("t3_instr", rsi[1], pat[j]);
    end
    rvq[1] = 1'b0;
    step();
    samp(); chk("t3_idle", rsv[1], 0);

    // flush during WAIT
    step();
    rvq[0] = 1'b1; raq[0] = 13'd1;
    step(); rvq[0] = 1'b0; flush = 1'b1;
    samp(); chk("t4_flush_ready", rdy[0], 0);
    step(); flush = 1'b0;
    samp(); chk("t4_no_valid", rsv[0], 0); chk("t4_ready_back", rdy[0], 1);
    step();
    samp(); chk("t4_no_valid2", rsv[0], 0);
    rvq[0] = 1'b1; raq[0] = 13'd2;
    step(); rvq[0] = 1'b0;
    samp();
    step();
    samp(); chk("t4_valid", rsv[0], 1); chk("t4_instr", rsi[0], 16'h3333);

    // load blocks acceptance
    step();
    rvq[0] = 1'b1; raq[0] = 13'd3;
    ld_en = 1'b1; ld_addr = 13'd6; ld_data = 16'h6666;
    samp(); chk("t5_ready_ld", rdy[0], 0);
    step(); ld_en = 1'b0; rvq[0] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      samp(); chk("t5_no_accept", rsv[0], 0);
      step();
    end

    // LATENCY 3: load on the edge before the response edge is visible
    rvq[2] = 1'b1; raq[2] = 13'd5;
    step(); rvq[2] = 1'b0;
    ld_en = 1'b1; ld_addr = 13'd5; ld_data = 16'hA5A5;
    step(); ld_en = 1'b0;
    samp(); chk("t6_wait_valid", rsv[2], 0);
    step();
    samp(); chk("t6_valid", rsv[2], 1); chk("t6_new_data", rsi[2], 16'hA5A5);

    // load on the response edge itself is not visible
    step();
    rvq[2] = 1'b1; raq[2] = 13'd5;
    step(); rvq[2] = 1'b0;
    step();
    ld_en = 1'b1; ld_addr = 13'd5; ld_data = 16'h5A5A;
    step(); ld_en = 1'b0;
    samp(); chk("t7_valid", rsv[2], 1); chk("t7_old_data", rsi[2], 16'hA5A5);
    step();
    rvq[2] = 1'b1; raq[2] = 13'd5;
    step(); rvq[2] = 1'b0;
    step(); step();
    samp(); chk("t7_later_data", rsi[2], 16'h5A5A);

    // out-of-range read on DEPTH 16; the 0x20 load must not alias onto word 0
    step();
    rvq[2] = 1'b1; raq[2] = 13'h0020;
    step(); rvq[2] = 1'b0;
    step(); step();
    samp();
    chk("t8_valid", rsv[2], 1);
    chk("t8_instr", rsi[2], 16'h0000);
    chk("t8_err", rse[2], 1);
    chk("t8_addr", rsa[2], 13'h0020);
    step();
    rvq[2] = 1'b1; raq[2] = 13'd0;
    step(); rvq[2] = 1'b0;
    step(); step();
    samp(); chk("t8_no_alias", rsi[2], 16'h1111); chk("t8_err_clear", rse[2], 0);

    // reset mid-WAIT
    step();
    rvq[0] = 1'b1; raq[0] = 13'd3;
    step(); rvq[0] = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t9_valid", rsv[0], 0);
    chk("t9_instr", rsi[0], 0);
    chk("t9_addr", rsa[0], 0);
    chk("t9_err", rse[0], 0);
    chk("t9_ready", rdy[0], 0);
    samp(); chk("t9_no_resp", rsv[0], 0);
    step();
    samp(); chk("t9_no_resp2", rsv[0], 0);
    step(); rst = 1'b1;
    samp(); chk("t9_no_resp3", rsv[0], 0);
    rvq[0] = 1'b1; raq[0] = 13'd3;
    step(); rvq[0] = 1'b0;
    samp();
    step();
    samp(); chk("t9_after_valid", rsv[0], 1); chk("t9_after_instr", rsi[0], 16'h4444);

    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
